// File: rtl/ov7670_cmd_parser_if.sv
// Command handoff between the UART command parser and the SCCB master.
// The parser drives the master side and the SCCB engine drives CMD_READY.
interface ov7670_cmd_parser_if #(
    parameter int ADR_W  = 8,
    parameter int DATA_W = 8
) ();
    logic              CMD_VALID;
    logic              CMD_READY;
    logic              CMD_WR;
    logic              CMD_RD;
    logic [ADR_W-1:0]  CMD_ADR;
    logic [DATA_W-1:0] CMD_DATA;

    modport master (
        output CMD_VALID, CMD_WR, CMD_RD, CMD_ADR, CMD_DATA,
        input  CMD_READY
    );

    modport slave (
        input  CMD_VALID, CMD_WR, CMD_RD, CMD_ADR, CMD_DATA,
        output CMD_READY
    );
endinterface

// File: rtl/ov7670_cmd_parser.sv
// ASCII command parser for the OV7670 SCCB path.
// Turns W/R/S text lines into SCCB commands and pixel-order updates.
module ov7670_cmd_parser #(
    parameter int                      ADR_DIGITS     = 2,
    parameter int                      DATA_DIGITS    = 2,
    parameter int                      SEL_DIGITS     = 3,
    parameter logic [3*SEL_DIGITS-1:0] SEL_INIT       = 9'b011010001,
    parameter int                      TIMEOUT_CYCLES = 4000000
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [7:0]                RX_DATA,
    input  logic                      RX_DATA_EN,
    ov7670_cmd_parser_if.master       cmd,
    output logic [3*SEL_DIGITS-1:0]   RGB_SEL,
    output logic                      RGB_SEL_UPD,
    output logic                      ERR,
    output logic [1:0]                ERR_CODE
);
    localparam int ADR_W  = 4 * ADR_DIGITS;
    localparam int DATA_W = 4 * DATA_DIGITS;
    localparam int SEL_W  = 3 * SEL_DIGITS;
    localparam int MAXD   = (ADR_DIGITS > DATA_DIGITS)
                          ? ((ADR_DIGITS > SEL_DIGITS) ? ADR_DIGITS : SEL_DIGITS)
                          : ((DATA_DIGITS > SEL_DIGITS) ? DATA_DIGITS : SEL_DIGITS);
    localparam int CW     = $clog2(MAXD + 1);
    localparam int TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TO_LAST =
        TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CW-1:0] ADR_LAST = CW'(ADR_DIGITS - 1);
    localparam logic [CW-1:0] DAT_LAST = CW'(DATA_DIGITS - 1);
    localparam logic [CW-1:0] SEL_LAST = CW'(SEL_DIGITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADR, S_DAT, S_SEL, S_TERM, S_DISCARD
    } state_e;

    typedef enum logic [1:0] {K_WR, K_RD, K_SEL} kind_e;

    state_e              state_q, state_d;
    kind_e               kind_q, kind_d;
    logic [CW-1:0]       dcnt_q, dcnt_d;
    logic [TW-1:0]       tcnt_q, tcnt_d;
    logic [ADR_W-1:0]    adr_sh_q, adr_sh_d;
    logic [DATA_W-1:0]   dat_sh_q, dat_sh_d;
    logic [SEL_W-1:0]    sel_sh_q, sel_sh_d;
    logic                valid_q, valid_d;
    logic                wr_q, wr_d;
    logic                rd_q, rd_d;
    logic [ADR_W-1:0]    adr_q, adr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [SEL_W-1:0]    rgb_q, rgb_d;
    logic                upd_q, upd_d;
    logic                err_q, err_d;
    logic [1:0]          code_q, code_d;

    logic       is_cr, is_lf, is_w, is_r, is_s, is_hex;
    logic [3:0] hex_val;

    // Classify the incoming byte: framing, command letters, hex digit value.
    always_comb begin
        is_cr   = (RX_DATA == 8'h0D);
        is_lf   = (RX_DATA == 8'h0A);
        is_w    = (RX_DATA == 8'h57) || (RX_DATA == 8'h77);
        is_r    = (RX_DATA == 8'h52) || (RX_DATA == 8'h72);
        is_s    = (RX_DATA == 8'h53) || (RX_DATA == 8'h73);
        is_hex  = 1'b0;
        hex_val = 4'h0;
        unique case (1'b1)
            (RX_DATA >= 8'h30 && RX_DATA <= 8'h39): begin
                is_hex  = 1'b1;
                hex_val = RX_DATA[3:0];
            end
            (RX_DATA >= 8'h41 && RX_DATA <= 8'h46),
            (RX_DATA >= 8'h61 && RX_DATA <= 8'h66): begin
                is_hex  = 1'b1;
                hex_val = RX_DATA[3:0] + 4'd9;
            end
            default: ;
        endcase
    end

    // Next-state: parser FSM, handshake, completion and inter-byte timeout.
    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        dcnt_d   = dcnt_q;
        tcnt_d   = tcnt_q;
        adr_sh_d = adr_sh_q;
        dat_sh_d = dat_sh_q;
        sel_sh_d = sel_sh_q;
        valid_d  = valid_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        adr_d    = adr_q;
        data_d   = data_q;
        rgb_d    = rgb_q;
        upd_d    = 1'b0;
        err_d    = 1'b0;
        code_d   = code_q;

        if (valid_q && cmd.CMD_READY) begin
            valid_d = 1'b0;
        end

        if (RX_DATA_EN) begin
            tcnt_d = '0;
            case (state_q)
                S_IDLE: begin
                    if (is_w || is_r) begin
                        state_d  = S_ADR;
                        kind_d   = is_w ? K_WR : K_RD;
                        dcnt_d   = '0;
                        adr_sh_d = '0;
                        dat_sh_d = '0;
                    end else if (is_s) begin
                        state_d  = S_SEL;
                        kind_d   = K_SEL;
                        dcnt_d   = '0;
                        sel_sh_d = '0;
                    end else if (!is_cr && !is_lf) begin
                        state_d = S_DISCARD;
                        err_d   = 1'b1;
                        code_d  = 2'd1;
                    end
                end
                S_ADR, S_DAT, S_SEL: begin
                    if (is_hex) begin
                        dcnt_d = dcnt_q + 1'b1;
                        if (state_q == S_ADR) begin
                            adr_sh_d = (adr_sh_q << 4) | ADR_W'(hex_val);
                            if (dcnt_q == ADR_LAST) begin
                                dcnt_d  = '0;
                                state_d = (kind_q == K_WR) ? S_DAT : S_TERM;
                            end
                        end else if (state_q == S_DAT) begin
                            dat_sh_d = (dat_sh_q << 4) | DATA_W'(hex_val);
                            if (dcnt_q == DAT_LAST) begin
                                dcnt_d  = '0;
                                state_d = S_TERM;
                            end
                        end else begin
                            sel_sh_d = (sel_sh_q << 3) | SEL_W'(hex_val[2:0]);
                            if (dcnt_q == SEL_LAST) begin
                                dcnt_d  = '0;
                                state_d = S_TERM;
                            end
                        end
                    end else if (is_lf) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                        code_d  = 2'd2;
                    end else begin
                        state_d = S_DISCARD;
                        err_d   = 1'b1;
                        code_d  = 2'd1;
                    end
                end
                S_TERM: begin
                    if (is_lf) begin
                        state_d = S_IDLE;
                        if (kind_q == K_SEL) begin
                            rgb_d = sel_sh_q;
                            upd_d = 1'b1;
                        end else if (!valid_q || cmd.CMD_READY) begin
                            valid_d = 1'b1;
                            wr_d    = (kind_q == K_WR);
                            rd_d    = (kind_q == K_RD);
                            adr_d   = adr_sh_q;
                            data_d  = (kind_q == K_WR) ? dat_sh_q : '0;
                        end else begin
                            err_d  = 1'b1;
                            code_d = 2'd0;
                        end
                    end else if (!is_cr) begin
                        state_d = S_DISCARD;
                        err_d   = 1'b1;
                        code_d  = 2'd1;
                    end
                end
                S_DISCARD: begin
                    if (is_lf) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (TIMEOUT_CYCLES != 0 && state_q != S_IDLE) begin
            if (tcnt_q == TO_LAST) begin
                tcnt_d  = '0;
                state_d = S_IDLE;
                err_d   = 1'b1;
                code_d  = 2'd3;
            end else begin
                tcnt_d = tcnt_q + 1'b1;
            end
        end
    end

    // Register all state and outputs; reset drops any partial or pending command.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            kind_q   <= K_WR;
            dcnt_q   <= '0;
            tcnt_q   <= '0;
            adr_sh_q <= '0;
            dat_sh_q <= '0;
            sel_sh_q <= '0;
            valid_q  <= 1'b0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            adr_q    <= '0;
            data_q   <= '0;
            rgb_q    <= SEL_INIT;
            upd_q    <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= 2'd0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            dcnt_q   <= dcnt_d;
            tcnt_q   <= tcnt_d;
            adr_sh_q <= adr_sh_d;
            dat_sh_q <= dat_sh_d;
            sel_sh_q <= sel_sh_d;
            valid_q  <= valid_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            adr_q    <= adr_d;
            data_q   <= data_d;
            rgb_q    <= rgb_d;
            upd_q    <= upd_d;
            err_q    <= err_d;
            code_q   <= code_d;
        end
    end

    assign cmd.CMD_VALID = valid_q;
    assign cmd.CMD_WR    = wr_q;
    assign cmd.CMD_RD    = rd_q;
    assign cmd.CMD_ADR   = adr_q;
    assign cmd.CMD_DATA  = data_q;
    assign RGB_SEL       = rgb_q;
    assign RGB_SEL_UPD   = upd_q;
    assign ERR           = err_q;
    assign ERR_CODE      = code_q;
endmodule

// File: tb/tb_ov7670_cmd_parser.sv
// Directed bench for the OV7670 command parser.
// Byte strings in, command/select/error outputs compared to hand values.
module tb_ov7670_cmd_parser;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_en;
    logic [8:0] rgb_sel;
    logic       rgb_upd;
    logic       err;
    logic [1:0] err_code;

    int n_chk = 0;
    int n_fail = 0;
    int n_errp = 0;
    int n_upd = 0;
    int last_code = 0;
    int base_e;
    int base_u;

    ov7670_cmd_parser_if #(.ADR_W(8), .DATA_W(8)) cmd_if ();

    ov7670_cmd_parser #(
        .ADR_DIGITS(2),
        .DATA_DIGITS(2),
        .SEL_DIGITS(3),
        .SEL_INIT(9'b011010001),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .CLK(clk),
        .RESET(reset),
        .RX_DATA(rx_data),
        .RX_DATA_EN(rx_en),
        .cmd(cmd_if.master),
        .RGB_SEL(rgb_sel),
        .RGB_SEL_UPD(rgb_upd),
        .ERR(err),
        .ERR_CODE(err_code)
    );

    always #5 clk = ~clk;

    // Tally every error/update pulse shortly after each edge.
    always @(posedge clk) begin
        #1;
        if (err) begin
            n_errp++;
            last_code = int'(err_code);
        end
        if (rgb_upd) n_upd++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_en   = 1'b1;
        @(negedge clk);
        rx_en   = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic chk_cmd(input string tag, input logic v, input logic w,
                           input logic r, input logic [7:0] a,
                           input logic [7:0] d);
        check({tag, "_valid"}, cmd_if.CMD_VALID, v);
        check({tag, "_wr"}, cmd_if.CMD_WR, w);
        check({tag, "_rd"}, cmd_if.CMD_RD, r);
        check({tag, "_adr"}, cmd_if.CMD_ADR, a);
        check({tag, "_data"}, cmd_if.CMD_DATA, d);
    endtask

    initial begin
        reset = 1'b1;
        rx_en = 1'b0;
        rx_data = 8'h00;
        cmd_if.CMD_READY = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", cmd_if.CMD_VALID, 1'b0);
        check("rst_adr", cmd_if.CMD_ADR, 8'h00);
        check("rst_data", cmd_if.CMD_DATA, 8'h00);
        check("rst_err", err, 1'b0);
        check("rst_code", err_code, 2'd0);
        check("rst_sel", rgb_sel, 9'b011010001);
        check("rst_upd", rgb_upd, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Write accepted with READY high, VALID drops next cycle.
        cmd_if.CMD_READY = 1'b1;
        base_e = n_errp;
        send_str("W12A5\r\n");
        chk_cmd("t1", 1'b1, 1'b1, 1'b0, 8'h12, 8'hA5);
        @(negedge clk);
        check("t1_clear", cmd_if.CMD_VALID, 1'b0);
        check("t1_noerr", n_errp - base_e, 0);

        // Read held pending; a second command is dropped with overflow.
        cmd_if.CMD_READY = 1'b0;
        send_str("r3f\n");
        chk_cmd("t2", 1'b1, 1'b0, 1'b1, 8'h3F, 8'h00);
        base_e = n_errp;
        send_str("W0102\n");
        check("t2_ovf_n", n_errp - base_e, 1);
        check("t2_ovf_code", last_code, 0);
        chk_cmd("t2_hold", 1'b1, 1'b0, 1'b1, 8'h3F, 8'h00);
        cmd_if.CMD_READY = 1'b1;
        @(negedge clk);
        check("t2_clear", cmd_if.CMD_VALID, 1'b0);

        // Pixel-order select update.
        base_u = n_upd;
        send_str("S123\n");
        check("t3_sel", rgb_sel, 9'b001010011);
        check("t3_upd_now", rgb_upd, 1'b1);
        repeat (3) @(negedge clk);
        check("t3_upd_n", n_upd - base_u, 1);
        check("t3_valid", cmd_if.CMD_VALID, 1'b0);

        // Bad hex digit discards the line; next line decodes.
        base_e = n_errp;
        send_str("W1G55\n");
        check("t4_err_n", n_errp - base_e, 1);
        check("t4_code", last_code, 1);
        check("t4_valid", cmd_if.CMD_VALID, 1'b0);
        send_str("W0001\n");
        chk_cmd("t4_next", 1'b1, 1'b1, 1'b0, 8'h00, 8'h01);
        check("t4_noerr", n_errp - base_e, 1);

        // Short command, unknown letter, empty line.
        base_e = n_errp;
        send_str("W12\n");
        check("t5_short_n", n_errp - base_e, 1);
        check("t5_short_code", last_code, 2);
        check("t5_short_valid", cmd_if.CMD_VALID, 1'b0);
        send_str("X\n");
        check("t5_bad_n", n_errp - base_e, 2);
        check("t5_bad_code", last_code, 1);
        send_str("\r\n");
        @(negedge clk);
        check("t5_empty_n", n_errp - base_e, 2);
        check("t5_empty_valid", cmd_if.CMD_VALID, 1'b0);

        // Mixed-case hex and letter; multiple CRs before LF.
        send_str("wAb5c\n");
        chk_cmd("t5_mixed", 1'b1, 1'b1, 1'b0, 8'hAB, 8'h5C);
        send_str("R7e\r\r\n");
        chk_cmd("t5_crcr", 1'b1, 1'b0, 1'b1, 8'h7E, 8'h00);
        send_str("R40Z\n");
        check("t5_term_n", n_errp - base_e, 3);
        check("t5_term_code", last_code, 1);

        // Timeout exactly 100 cycles after the last strobe.
        send_str("W1");
        base_e = n_errp;
        repeat (99) @(negedge clk);
        check("t6_early", n_errp - base_e, 0);
        @(negedge clk);
        check("t6_to_err", err, 1'b1);
        check("t6_to_code", err_code, 2'd3);
        @(negedge clk);
        check("t6_to_pulse", err, 1'b0);

        // Reset mid-command then a clean read.
        send_str("R4");
        reset = 1'b1;
        @(negedge clk);
        check("t6_rst_valid", cmd_if.CMD_VALID, 1'b0);
        check("t6_rst_sel", rgb_sel, 9'b011010001);
        check("t6_rst_adr", cmd_if.CMD_ADR, 8'h00);
        check("t6_rst_err", err, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        send_str("R40\n");
        chk_cmd("t6_after", 1'b1, 1'b0, 1'b1, 8'h40, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_fail, n_chk);
        $finish;
    end
endmodule
